// File: rtl/alu_multicycle.sv
// alu_multicycle: parametrised shared-bus ALU with a Temp operand register,
// a result register G, status flags and a tri-state bus driver. Iterative
// multiply and variable-amount left shift run under an IDLE/RUN/DONE FSM
// with a Busy/Done handshake. All state updates on the falling edge of CLKb.
//
// Configuration macro: ALU_MUL_EN
//   defined   -> FN 1110 is a WIDTH-cycle shift-add multiply
//   undefined -> FN 1110 is a single-cycle op writing G = 0
//
// Ports:
//   CLKb   in   clock (falling-edge active)
//   Reset  in   synchronous active-high reset
//   OP     in   bus operand
//   FN     in   function select
//   Ain    in   load Temp from OP
//   Gin    in   execute FN / start a multi-cycle op
//   Gout   in   drive G onto Q
//   Busy   out  multi-cycle op in progress
//   Done   out  one-cycle pulse when a multi-cycle result lands in G
//   Flags  out  {Z,N,C,V} of the last G write
//   Q      out  G when Gout=1, else high-Z
module alu_multicycle #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             CLKb,
    input  logic             Reset,
    input  logic [WIDTH-1:0] OP,
    input  logic [3:0]       FN,
    input  logic             Ain,
    input  logic             Gin,
    input  logic             Gout,
    output logic             Busy,
    output logic             Done,
    output logic [3:0]       Flags,
    output logic [WIDTH-1:0] Q
);
    localparam int unsigned CNT_W   = $clog2(WIDTH) + 1;
    localparam int unsigned MSB     = WIDTH - 1;
    localparam logic [3:0]  FN_SHLV = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_temp;
    logic [WIDTH-1:0] r_g;
    logic [3:0]       r_flags;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sh;       // SHLV shift register / MUL multiplicand
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mplier;
    logic             r_is_mul;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_sh : '0);
`endif

    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [CNT_W-1:0] w_n;
    logic [CNT_W-1:0] w_shcnt;

    assign w_sum   = {1'b0, OP} + {1'b0, r_temp};
    assign w_dif   = {1'b0, OP} - {1'b0, r_temp};
    assign w_n     = r_temp[CNT_W-1:0];
    // Shifts of WIDTH or more just clear the register, so cap the iterations.
    assign w_shcnt = (w_n >= CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : w_n;

    // Single-cycle result and carry/overflow
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (FN)
            4'b0000: w_res = OP;
            4'b0001: w_res = r_temp;
            4'b0010, 4'b1100: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (OP[MSB] == r_temp[MSB]) && (w_sum[MSB] != OP[MSB]);
            end
            4'b0011, 4'b1101: begin
                w_res = w_dif[WIDTH-1:0];
                w_c   = w_dif[WIDTH];     // borrow: OP < Temp unsigned
                w_v   = (OP[MSB] != r_temp[MSB]) && (w_dif[MSB] != OP[MSB]);
            end
            4'b0100: begin
                w_res = -r_temp;
                w_c   = |r_temp;
                w_v   = r_temp[MSB] & w_res[MSB];   // only the most negative value
            end
            4'b0101: w_res = ~r_temp;
            4'b0110: w_res = OP & r_temp;
            4'b0111: w_res = OP | r_temp;
            4'b1000: w_res = OP ^ r_temp;
            4'b1001: begin
                w_res = {OP[WIDTH-2:0], 1'b0};
                w_c   = OP[MSB];
            end
            4'b1010: begin
                w_res = {1'b0, OP[WIDTH-1:1]};
                w_c   = OP[0];
            end
            4'b1011: begin
                w_res = {OP[MSB], OP[WIDTH-1:1]};
                w_c   = OP[0];
            end
            default: w_res = '0;
        endcase
    end

    // Operand, result, flags and control FSM
    always_ff @(negedge CLKb) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_temp   <= '0;
            r_g      <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_sh     <= '0;
`ifdef ALU_MUL_EN
            r_acc    <= '0;
            r_mplier <= '0;
            r_is_mul <= 1'b0;
`endif
        end else begin
            if (Ain) begin
                r_temp <= OP;
            end
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (Gin) begin
                        if (FN == FN_SHLV) begin
                            if (w_n == '0) begin
                                r_g     <= OP;
                                r_flags <= {~|OP, OP[MSB], 2'b00};
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_sh     <= OP;
                                r_cnt    <= w_shcnt;
                                r_state  <= S_RUN;
                                r_busy   <= 1'b1;
`ifdef ALU_MUL_EN
                                r_is_mul <= 1'b0;
`endif
                            end
                        end
`ifdef ALU_MUL_EN
                        else if (FN == 4'b1110) begin
                            r_sh     <= OP;
                            r_mplier <= r_temp;
                            r_acc    <= '0;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_is_mul <= 1'b1;
                            r_state  <= S_RUN;
                            r_busy   <= 1'b1;
                        end
`endif
                        else begin
                            r_g     <= w_res;
                            r_flags <= {~|w_res, w_res[MSB], w_c, w_v};
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
`ifdef ALU_MUL_EN
                    r_acc    <= w_acc_nxt;
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
`endif
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`ifdef ALU_MUL_EN
                        if (r_is_mul) begin
                            r_g     <= w_acc_nxt;
                            r_flags <= {~|w_acc_nxt, w_acc_nxt[MSB], 2'b00};
                        end else
`endif
                        begin
                            r_g     <= {r_sh[WIDTH-2:0], 1'b0};
                            r_flags <= {~|r_sh[WIDTH-2:0], r_sh[WIDTH-2], r_sh[MSB], 1'b0};
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy  = r_busy;
    assign Done  = r_done;
    assign Flags = r_flags;
    assign Q     = Gout ? r_g : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=10): table of single-cycle
// vectors plus hand sequences for SHLV, MUL, reset abort and Ain/Gin overlap.
module tb_alu_multicycle;
    logic       CLKb;
    logic       rst;
    logic [9:0] op;
    logic [3:0] fn;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       busy;
    logic       done;
    logic [3:0] flags;
    wire  [9:0] q;

    int n_checks = 0;
    int n_errors = 0;

    alu_multicycle #(.WIDTH(10)) dut (
        .CLKb (CLKb),
        .Reset(rst),
        .OP   (op),
        .FN   (fn),
        .Ain  (ain),
        .Gin  (gin),
        .Gout (gout),
        .Busy (busy),
        .Done (done),
        .Flags(flags),
        .Q    (q)
    );

    initial CLKb = 1'b1;
    always #5 CLKb = ~CLKb;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLKb);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic load_temp(input logic [9:0] v);
        ain = 1'b1; gin = 1'b0; op = v;
        tick();
        ain = 1'b0;
    endtask

    task automatic single(input logic [3:0] f, input logic [9:0] o);
        gin = 1'b1; fn = f; op = o;
        tick();
        gin = 1'b0;
    endtask

    // Start a multi-cycle op, count Busy cycles, poke Gin during RUN, check result.
    task automatic run_op(input string nm, input logic [3:0] fn_i, input logic [9:0] op_i,
                          input int exp_cyc, input logic [9:0] exp_g, input logic [3:0] exp_f,
                          input logic [3:0] f_mask, input bit follow);
        int         cyc;
        bit         overlap;
        logic [9:0] g_before;
        g_before = q;
        fn = fn_i; op = op_i; gin = 1'b1;
        tick();
        gin = 1'b0;
        cyc = 0;
        overlap = 1'b0;
        while (busy === 1'b1 && cyc < 40) begin
            if (done === 1'b1) overlap = 1'b1;
            if (cyc == 1) begin
                gin = 1'b1; fn = 4'b0000; op = 10'h3FF;
            end else begin
                gin = 1'b0; fn = fn_i; op = ~op_i;
            end
            tick();
            cyc++;
            if (cyc == 1 && busy === 1'b1) check({nm, " q_in_run"}, 32'(q), 32'(g_before));
        end
        gin = 1'b0;
        check({nm, " busy_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({nm, " done"}, 32'(done), 32'd1);
        check({nm, " busy_done_overlap"}, 32'(overlap), 32'd0);
        check({nm, " g"}, 32'(q), 32'(exp_g));
        check({nm, " flags"}, 32'(flags & f_mask), 32'(exp_f & f_mask));
        if (follow) begin
            gin = 1'b1; fn = 4'b0000; op = 10'h0AB;
        end
        tick();
        gin = 1'b0;
        check({nm, " done_clear"}, 32'(done), 32'd0);
        if (follow) check({nm, " gin_in_done"}, 32'(q), 32'h0AB);
    endtask

    typedef struct {
        logic [3:0] fn;
        logic [9:0] op;
        logic [9:0] tmp;
        logic [9:0] g;
        logic [3:0] f;
    } vec_t;

    vec_t vecs [0:17];

    initial begin
        vecs[0]  = '{4'b0000, 10'h000, 10'h123, 10'h000, 4'b1000};
        vecs[1]  = '{4'b0001, 10'h3FF, 10'h2A5, 10'h2A5, 4'b0100};
        vecs[2]  = '{4'b0010, 10'h3FE, 10'h005, 10'h003, 4'b0010};
        vecs[3]  = '{4'b1100, 10'h1FF, 10'h001, 10'h200, 4'b0101};
        vecs[4]  = '{4'b0011, 10'h005, 10'h005, 10'h000, 4'b1000};
        vecs[5]  = '{4'b1101, 10'h003, 10'h005, 10'h3FE, 4'b0110};
        vecs[6]  = '{4'b0011, 10'h200, 10'h001, 10'h1FF, 4'b0001};
        vecs[7]  = '{4'b0100, 10'h000, 10'h001, 10'h3FF, 4'b0110};
        vecs[8]  = '{4'b0100, 10'h000, 10'h200, 10'h200, 4'b0111};
        vecs[9]  = '{4'b0100, 10'h000, 10'h000, 10'h000, 4'b1000};
        vecs[10] = '{4'b0101, 10'h000, 10'h0F0, 10'h30F, 4'b0100};
        vecs[11] = '{4'b0110, 10'h3C3, 10'h0FF, 10'h0C3, 4'b0000};
        vecs[12] = '{4'b0111, 10'h300, 10'h00F, 10'h30F, 4'b0100};
        vecs[13] = '{4'b1000, 10'h155, 10'h155, 10'h000, 4'b1000};
        vecs[14] = '{4'b1001, 10'h201, 10'h000, 10'h002, 4'b0010};
        vecs[15] = '{4'b1010, 10'h201, 10'h000, 10'h100, 4'b0010};
        vecs[16] = '{4'b1011, 10'h201, 10'h000, 10'h300, 4'b0110};
        vecs[17] = '{4'b1011, 10'h0F2, 10'h000, 10'h079, 4'b0000};

        rst = 1'b1; op = '0; fn = '0; ain = 1'b0; gin = 1'b0; gout = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        check("reset q", 32'(q), 32'h000);

        // Single-cycle table
        for (int i = 0; i < 18; i++) begin
            load_temp(vecs[i].tmp);
            single(vecs[i].fn, vecs[i].op);
            check($sformatf("vec%0d g", i), 32'(q), 32'(vecs[i].g));
            check($sformatf("vec%0d flags", i), 32'(flags), 32'(vecs[i].f));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
        end

        // Add then subtract on the same Temp
        load_temp(10'h005);
        single(4'b0010, 10'h3FE);
        check("addsub add g", 32'(q), 32'h003);
        check("addsub add flags", 32'(flags), 32'b0010);
        single(4'b0011, 10'h005);
        check("addsub sub g", 32'(q), 32'h000);
        check("addsub sub flags", 32'(flags), 32'b1000);

        // Ain and Gin together: ALU sees the old Temp
        load_temp(10'h0AA);
        ain = 1'b1; gin = 1'b1; fn = 4'b0001; op = 10'h010;
        tick();
        ain = 1'b0; gin = 1'b0;
        check("ain_gin old temp", 32'(q), 32'h0AA);
        single(4'b0001, 10'h000);
        check("ain_gin new temp", 32'(q), 32'h010);

        // SHLV: 3 bits, then n=0, then n >= WIDTH
        load_temp(10'd3);
        run_op("shlv3", 4'b1111, 10'h201, 3, 10'h008, 4'b0000, 4'b1111, 1'b1);
        load_temp(10'd0);
        run_op("shlv0", 4'b1111, 10'h155, 0, 10'h155, 4'b0000, 4'b1111, 1'b0);
        load_temp(10'd12);
        run_op("shlv12", 4'b1111, 10'h155, 10, 10'h000, 4'b1000, 4'b1101, 1'b0);

`ifdef ALU_MUL_EN
        load_temp(10'h00D);
        run_op("mul", 4'b1110, 10'h00B, 10, 10'h08F, 4'b0000, 4'b1111, 1'b0);
        load_temp(10'h00D);
        single(4'b0000, 10'h155);
        fn = 4'b1110; op = 10'h00B; gin = 1'b1;
`else
        load_temp(10'h005);
        single(4'b0000, 10'h155);
        single(4'b1110, 10'h007);
        check("mul_off g", 32'(q), 32'h000);
        check("mul_off flags", 32'(flags), 32'b1000);
        check("mul_off busy", 32'(busy), 32'd0);
        check("mul_off done", 32'(done), 32'd0);
        load_temp(10'd8);
        single(4'b0000, 10'h155);
        fn = 4'b1111; op = 10'h0AB; gin = 1'b1;
`endif
        // Reset in the third RUN cycle aborts without writing G
        tick();
        gin = 1'b0;
        check("abort started", 32'(busy), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort flags", 32'(flags), 32'd0);
        check("abort q", 32'(q), 32'h000);
        tick();
        check("abort no late done", 32'(done), 32'd0);
        check("abort g held", 32'(q), 32'h000);
        single(4'b0001, 10'h3FF);
        check("abort temp cleared", 32'(q), 32'h000);
        check("abort temp flags", 32'(flags), 32'b1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
